// File: rtl/i2c_bus_cond_det_if.sv
// ---------------------------------------------------------------------------
// i2c_bus_cond_det_if : raw I2C pins plus filtered lines and bus-condition flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface i2c_bus_cond_det_if;
  logic scl_ai;
  logic sda_ai;
  logic scl_o;
  logic sda_o;
  logic scl_rise_o;
  logic scl_fall_o;
  logic start_o;
  logic rstart_o;
  logic stop_o;
  logic busy_o;
  logic timeout_o;

  // master: the detector itself; slave: the protocol FSM / pad side
  modport master (
    input  scl_ai, sda_ai,
    output scl_o, sda_o, scl_rise_o, scl_fall_o,
           start_o, rstart_o, stop_o, busy_o, timeout_o
  );

  modport slave (
    output scl_ai, sda_ai,
    input  scl_o, sda_o, scl_rise_o, scl_fall_o,
           start_o, rstart_o, stop_o, busy_o, timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/i2c_bus_cond_det.sv
// ---------------------------------------------------------------------------
// i2c_bus_cond_det : SCL/SDA synchronizer, glitch filter, START/STOP detector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_bus_cond_det #(
  parameter int FILT_LEN    = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  i2c_bus_cond_det_if.master bus
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {bus.sda_ai, bus.scl_ai};

  // Index 0 is SCL, index 1 is SDA
  for (genvar i = 0; i < 2; i++) begin : g_line
    logic          s1_q;
    logic          s2_q;
    logic          f_q;
    logic          f_d;
    logic [FW-1:0] cnt_q;
    logic [FW-1:0] cnt_d;

    always_comb begin
      f_d   = f_q;
      cnt_d = '0;
      if (s2_q != f_q) begin
        if (cnt_q == FILT_LAST) begin
          f_d = s2_q;
        end else begin
          cnt_d = cnt_q + FW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q  <= 1'b1;
        s2_q  <= 1'b1;
        f_q   <= 1'b1;
        cnt_q <= '0;
      end else begin
        s1_q  <= raw[i];
        s2_q  <= s1_q;
        f_q   <= f_d;
        cnt_q <= cnt_d;
      end
    end

    assign filt[i] = f_q;
  end

  logic scl;
  logic sda;
  logic scl_prev_q;
  logic sda_prev_q;
  logic start_c;
  logic stop_c;

  assign scl = filt[0];
  assign sda = filt[1];

  // A simultaneous SCL change makes scl_prev_q != scl, which suppresses both conditions
  assign start_c = scl_prev_q & scl & sda_prev_q & ~sda;
  assign stop_c  = scl_prev_q & scl & ~sda_prev_q & sda;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic          start_q;
  logic          start_d;
  logic          rstart_q;
  logic          rstart_d;
  logic          stop_q;
  logic          stop_d;
  logic          rise_q;
  logic          fall_q;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = '0;
    start_d  = 1'b0;
    rstart_d = 1'b0;
    stop_d   = stop_c;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (start_c) begin
          rstart_d = 1'b1;
        end else if (stop_c) begin
          state_d = ST_IDLE;
        end else if (!scl) begin
          if (tcnt_q == TO_LAST) begin
            state_d = ST_TIMEOUT;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_TIMEOUT: begin
        if (start_c) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
        end else if (stop_c || (scl && sda)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      start_q    <= 1'b0;
      rstart_q   <= 1'b0;
      stop_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      scl_prev_q <= scl;
      sda_prev_q <= sda;
      start_q    <= start_d;
      rstart_q   <= rstart_d;
      stop_q     <= stop_d;
      rise_q     <= ~scl_prev_q & scl;
      fall_q     <= scl_prev_q & ~scl;
    end
  end

  assign bus.scl_o      = scl;
  assign bus.sda_o      = sda;
  assign bus.scl_rise_o = rise_q;
  assign bus.scl_fall_o = fall_q;
  assign bus.start_o    = start_q;
  assign bus.rstart_o   = rstart_q;
  assign bus.stop_o     = stop_q;
  assign bus.busy_o     = (state_q == ST_BUSY);
  assign bus.timeout_o  = (state_q == ST_TIMEOUT);

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_cond_det.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_cond_det : scenario tasks checked against a cycle-level bus model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2c_bus_cond_det;

  localparam int FILT_LEN    = 3;
  localparam int TIMEOUT_CYC = 20;

  // Observation vector bit positions
  localparam int B_SCL = 8, B_SDA = 7, B_RISE = 6, B_FALL = 5, B_START = 4;
  localparam int B_RSTART = 3, B_STOP = 2, B_BUSY = 1, B_TO = 0;
  localparam logic [8:0] RESET_VEC = 9'b110000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_bus_cond_det_if bus ();

  i2c_bus_cond_det #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed { logic r; logic s; logic d; } stim_t;
  stim_t      q_stim[$];
  logic [8:0] tr_dut[$];
  logic [8:0] tr_mod[$];

  // ---------------- behavioural bus model ----------------
  logic [1:0]  m_hs, m_hd;        // two-sample pin delay
  logic [31:0] m_ws, m_wd;        // recent presented samples, newest in bit 0
  logic        m_scl, m_sda, m_pscl, m_psda;
  int          m_state;           // 0 idle, 1 busy, 2 timeout
  int          m_low;
  logic        e_rise, e_fall, e_start, e_rstart, e_stop;

  // A line flips once its last FILT_LEN presented samples all disagree with it
  function automatic void filt_line(input logic pres, inout logic f, inout logic [31:0] w);
    logic [31:0] mask;
    mask = (32'd1 << FILT_LEN) - 32'd1;
    w = {w[30:0], pres};
    if ((w & mask) == (f ? 32'd0 : mask)) begin
      f = ~f;
      w = {32{f}};
    end
  endfunction

  task automatic model_step(input logic r, input logic s, input logic d);
    logic ps, pd, cond_start;
    if (r) begin
      m_hs = 2'b11; m_hd = 2'b11; m_ws = '1; m_wd = '1;
      m_scl = 1'b1; m_sda = 1'b1; m_pscl = 1'b1; m_psda = 1'b1;
      m_state = 0; m_low = 0;
      {e_rise, e_fall, e_start, e_rstart, e_stop} = '0;
    end else begin
      ps = m_hs[1]; pd = m_hd[1];
      m_hs = {m_hs[0], s};
      m_hd = {m_hd[0], d};
      cond_start = m_pscl && m_scl && m_psda && !m_sda;
      e_stop   = m_pscl && m_scl && !m_psda && m_sda;
      e_rise   = !m_pscl && m_scl;
      e_fall   = m_pscl && !m_scl;
      e_start  = cond_start && (m_state != 1);
      e_rstart = cond_start && (m_state == 1);
      if (m_state == 0) begin
        if (cond_start) begin m_state = 1; m_low = 0; end
      end else if (m_state == 1) begin
        if (cond_start) m_low = 0;
        else if (e_stop) m_state = 0;
        else if (!m_scl) begin
          m_low++;
          if (m_low >= TIMEOUT_CYC) begin m_state = 2; m_low = 0; end
        end else m_low = 0;
      end else begin
        if (cond_start) begin m_state = 1; m_low = 0; end
        else if (e_stop || (m_scl && m_sda)) m_state = 0;
      end
      m_pscl = m_scl; m_psda = m_sda;
      filt_line(ps, m_scl, m_ws);
      filt_line(pd, m_sda, m_wd);
    end
  endtask

  function automatic logic [8:0] mod_vec();
    return {m_scl, m_sda, e_rise, e_fall, e_start, e_rstart, e_stop,
            m_state == 1, m_state == 2};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.scl_o, bus.sda_o, bus.scl_rise_o, bus.scl_fall_o, bus.start_o,
            bus.rstart_o, bus.stop_o, bus.busy_o, bus.timeout_o};
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic hold(input logic r, input logic s, input logic d, input int n);
    for (int i = 0; i < n; i++) q_stim.push_back('{r: r, s: s, d: d});
  endtask

  task automatic play();
    tr_dut.delete();
    tr_mod.delete();
    foreach (q_stim[i]) begin
      rst        = q_stim[i].r;
      bus.scl_ai = q_stim[i].s;
      bus.sda_ai = q_stim[i].d;
      @(posedge clk);
      model_step(q_stim[i].r, q_stim[i].s, q_stim[i].d);
      #1;
      tr_dut.push_back(dut_vec());
      tr_mod.push_back(mod_vec());
    end
    q_stim.delete();
  endtask

  function automatic int cnt_bit(input int b, input int from);
    int n = 0;
    for (int i = from; i < tr_dut.size(); i++) if (tr_dut[i][b]) n++;
    return n;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hold(1, 1, 1, 3);
    hold(0, 1, 1, 5);
    play();
    n_cmp++;
    if (tr_dut[0] !== RESET_VEC) begin
      n_err++; $display("FAIL reset_vec: got %b want %b", tr_dut[0], RESET_VEC);
    end
    n_cmp++;
    if (tr_dut[7] !== RESET_VEC) begin
      n_err++; $display("FAIL idle_vec: got %b want %b", tr_dut[7], RESET_VEC);
    end
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL reset_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  task automatic test_start();
    int k;
    hold(1, 1, 1, 2);
    hold(0, 1, 1, 6);
    k = q_stim.size();
    hold(0, 1, 0, 10);
    play();
    n_cmp++;
    if (tr_dut[k+3][B_SDA] !== 1'b1) begin
      n_err++; $display("FAIL start_sda_early: got %b want 1", tr_dut[k+3][B_SDA]);
    end
    n_cmp++;
    if (tr_dut[k+4][B_SDA] !== 1'b0) begin
      n_err++; $display("FAIL start_sda_lat: got %b want 0", tr_dut[k+4][B_SDA]);
    end
    n_cmp++;
    if ({tr_dut[k+4][B_START], tr_dut[k+5][B_START], tr_dut[k+6][B_START]} !== 3'b010) begin
      n_err++; $display("FAIL start_pulse: got %b want 010",
                        {tr_dut[k+4][B_START], tr_dut[k+5][B_START], tr_dut[k+6][B_START]});
    end
    n_cmp++;
    if (tr_dut[k+5][B_BUSY] !== 1'b1) begin
      n_err++; $display("FAIL start_busy: got %b want 1", tr_dut[k+5][B_BUSY]);
    end
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL start_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  task automatic test_glitch();
    int sda_low;
    hold(1, 1, 1, 2);
    hold(0, 1, 1, 6);
    hold(0, 1, 0, 2);
    hold(0, 1, 1, 12);
    play();
    sda_low = 0;
    foreach (tr_dut[i]) if (!tr_dut[i][B_SDA]) sda_low++;
    n_cmp++;
    if (sda_low !== 0) begin
      n_err++; $display("FAIL glitch_sda: got %0d low cycles want 0", sda_low);
    end
    n_cmp++;
    if (cnt_bit(B_START, 0) + cnt_bit(B_STOP, 0) !== 0) begin
      n_err++; $display("FAIL glitch_cond: got %0d conditions want 0",
                        cnt_bit(B_START, 0) + cnt_bit(B_STOP, 0));
    end
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL glitch_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  task automatic test_transfer();
    logic d, nd;
    int   last;
    hold(1, 1, 1, 2);
    hold(0, 1, 1, 8);
    hold(0, 1, 0, 10);
    d = 1'b0;
    for (int b = 0; b < 8; b++) begin
      nd = (b == 7) ? 1'b1 : logic'($urandom_range(0, 1));
      hold(0, 0, d, 8);
      hold(0, 0, nd, 8);
      hold(0, 1, nd, 24);
      d = nd;
    end
    hold(0, 1, 0, 12);
    hold(0, 1, 1, 12);
    play();
    last = tr_dut.size() - 1;
    n_cmp++;
    if (cnt_bit(B_RISE, 0) !== 8) begin
      n_err++; $display("FAIL xfer_rise: got %0d want 8", cnt_bit(B_RISE, 0));
    end
    n_cmp++;
    if ({cnt_bit(B_START, 0), cnt_bit(B_RSTART, 0), cnt_bit(B_STOP, 0)} !== {32'd1, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL xfer_conds: got start %0d rstart %0d stop %0d want 1 1 1",
                        cnt_bit(B_START, 0), cnt_bit(B_RSTART, 0), cnt_bit(B_STOP, 0));
    end
    n_cmp++;
    if (tr_dut[last][1:0] !== 2'b00) begin
      n_err++; $display("FAIL xfer_idle: got busy/timeout %b want 00", tr_dut[last][1:0]);
    end
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL xfer_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int fi, ti, last;
    hold(1, 1, 1, 2);
    hold(0, 1, 1, 6);
    hold(0, 1, 0, 10);
    hold(0, 0, 0, 35);
    hold(0, 1, 1, 15);
    play();
    fi = -1; ti = -1;
    foreach (tr_dut[i]) begin
      if (fi < 0 && i > 10 && !tr_dut[i][B_SCL]) fi = i;
      if (ti < 0 && tr_dut[i][B_TO]) ti = i;
    end
    last = tr_dut.size() - 1;
    n_cmp++;
    if (fi < 0 || ti < 0 || (ti - fi) != TIMEOUT_CYC) begin
      n_err++; $display("FAIL to_delay: got fall@%0d timeout@%0d want gap %0d", fi, ti, TIMEOUT_CYC);
    end else begin
      n_cmp++;
      if (tr_dut[ti][1:0] !== 2'b01 || tr_dut[ti-1][1:0] !== 2'b10) begin
        n_err++; $display("FAIL to_state: got %b then %b want 10 then 01",
                          tr_dut[ti-1][1:0], tr_dut[ti][1:0]);
      end
    end
    n_cmp++;
    if (cnt_bit(B_STOP, 0) !== 0 || tr_dut[last][1:0] !== 2'b00) begin
      n_err++; $display("FAIL to_release: got stops %0d state %b want 0 00",
                        cnt_bit(B_STOP, 0), tr_dut[last][1:0]);
    end
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL to_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int j, last;
    hold(1, 1, 1, 2);
    hold(0, 1, 1, 6);
    hold(0, 1, 0, 10);
    hold(0, 0, 0, 10);
    j = q_stim.size();
    hold(1, 0, 0, 1);
    hold(0, 0, 0, 10);
    hold(0, 0, 1, 10);
    hold(0, 1, 1, 10);
    play();
    last = tr_dut.size() - 1;
    n_cmp++;
    if (tr_dut[j-1][B_BUSY] !== 1'b1) begin
      n_err++; $display("FAIL rmid_busy_before: got %b want 1", tr_dut[j-1][B_BUSY]);
    end
    n_cmp++;
    if (tr_dut[j] !== RESET_VEC) begin
      n_err++; $display("FAIL rmid_vec: got %b want %b", tr_dut[j], RESET_VEC);
    end
    n_cmp++;
    if (cnt_bit(B_START, j) + cnt_bit(B_STOP, j) + cnt_bit(B_BUSY, j) !== 0) begin
      n_err++; $display("FAIL rmid_after: got start %0d stop %0d busy %0d want 0 0 0",
                        cnt_bit(B_START, j), cnt_bit(B_STOP, j), cnt_bit(B_BUSY, j));
    end
    n_cmp++;
    if (tr_dut[last] !== RESET_VEC) begin
      n_err++; $display("FAIL rmid_final: got %b want %b", tr_dut[last], RESET_VEC);
    end
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL rmid_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  task automatic test_same_edge();
    hold(1, 1, 1, 2);
    hold(0, 1, 1, 6);
    hold(0, 0, 0, 10);
    hold(0, 1, 1, 10);
    play();
    n_cmp++;
    if (cnt_bit(B_START, 0) + cnt_bit(B_STOP, 0) + cnt_bit(B_BUSY, 0) !== 0) begin
      n_err++; $display("FAIL same_cond: got start %0d stop %0d busy %0d want 0 0 0",
                        cnt_bit(B_START, 0), cnt_bit(B_STOP, 0), cnt_bit(B_BUSY, 0));
    end
    n_cmp++;
    if (cnt_bit(B_FALL, 0) !== 1 || cnt_bit(B_RISE, 0) !== 1) begin
      n_err++; $display("FAIL same_edges: got fall %0d rise %0d want 1 1",
                        cnt_bit(B_FALL, 0), cnt_bit(B_RISE, 0));
    end
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL same_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  task automatic test_random();
    logic s, d;
    int   r, n;
    s = 1'b1; d = 1'b1;
    hold(1, 1, 1, 2);
    while (q_stim.size() < 2500) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        hold(1, s, d, 1);
      end else if (r < 15) begin
        n = int'($urandom_range(1, FILT_LEN + 1));
        if (r[0]) hold(0, ~s, d, n); else hold(0, s, ~d, n);
      end else begin
        case ($urandom_range(0, 3))
          0:       s = ~s;
          1:       d = ~d;
          2:       begin s = ~s; d = ~d; end
          default: ;
        endcase
        hold(0, s, d, int'($urandom_range(1, 30)));
      end
    end
    play();
    foreach (tr_dut[i]) begin
      n_cmp++;
      if (tr_dut[i] !== tr_mod[i]) begin
        n_err++; $display("FAIL rand_model cyc %0d: got %b want %b", i, tr_dut[i], tr_mod[i]);
      end
    end
  endtask

  initial begin
    bus.scl_ai = 1'b1;
    bus.sda_ai = 1'b1;
    model_step(1'b1, 1'b1, 1'b1);
    test_reset();
    test_start();
    test_glitch();
    test_transfer();
    test_timeout();
    test_reset_mid();
    test_same_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
